// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between two requesters.
// Optional locked back-to-back grants are enabled with `define MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int N        = 32,
    parameter int A        = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req0,
    input  logic         req1,
    input  logic         lock0,
    input  logic         lock1,
    input  logic         wr_ena0,
    input  logic         wr_ena1,
    input  logic [A-1:0] addr0,
    input  logic [A-1:0] addr1,
    input  logic [N-1:0] wr_data0,
    input  logic [N-1:0] wr_data1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] rd_data0,
    output logic [N-1:0] rd_data1,
    output logic [A-1:0] mem_addr,
    output logic         mem_wr_ena,
    output logic [N-1:0] mem_wr_data,
    input  logic [N-1:0] mem_rd_data,
    output logic         busy,
    output logic         gnt_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           last_gnt;
    logic           gnt_id_q;
    logic           lat_we;
    logic [A-1:0]   lat_addr;
    logic [N-1:0]   lat_wd;
    logic           ack0_q;
    logic           ack1_q;
    logic [N-1:0]   rd0_q;
    logic [N-1:0]   rd1_q;
    logic           grant;
    logic           win;
    logic           elig0;
    logic           elig1;

`ifdef MEM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic           lock_lat;
    logic [CW-1:0]  lock_cnt;
    logic           lock_full;
    logic           relock0;
    logic           relock1;
    logic           locked;

    assign lock_full = (lock_cnt == CW'(MAX_LOCK));
    // Locked re-grant: the acked requester keeps the port unless the cap is hit and the other side waits
    assign relock0 = ack0_q & lock_lat & req0 & ~(lock_full & req1);
    assign relock1 = ack1_q & lock_lat & req1 & ~(lock_full & req0);
`else
    logic unused_lock;
    assign unused_lock = lock0 | lock1;
`endif

    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and grant decision
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = last_gnt;
`ifdef MEM_ARB_LOCK_EN
        locked  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                if (relock0 | relock1) begin
                    grant  = 1'b1;
                    win    = relock1;
                    locked = 1'b1;
                end else
`endif
                if (elig0 & elig1) begin
                    grant = 1'b1;
                    win   = ~last_gnt;
                end else if (elig0) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (elig1) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
                if (grant) state_d = ISSUE;
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request; these latches drive the memory port directly
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_gnt <= 1'b1;
            gnt_id_q <= 1'b1;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
        end else if (grant) begin
            last_gnt <= win;
            gnt_id_q <= win;
            lat_we   <= win ? wr_ena1 : wr_ena0;
            lat_addr <= win ? addr1 : addr0;
            lat_wd   <= win ? wr_data1 : wr_data0;
        end
    end

    // Completion: one-cycle ack and read-data capture at the end of RESP
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            rd0_q  <= '0;
            rd1_q  <= '0;
        end else begin
            ack0_q <= (state_q == RESP) & ~gnt_id_q;
            ack1_q <= (state_q == RESP) & gnt_id_q;
            if ((state_q == RESP) && !lat_we) begin
                if (gnt_id_q) rd1_q <= mem_rd_data;
                else          rd0_q <= mem_rd_data;
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    // Lock bookkeeping: count consecutive locked grants, clear on a fresh grant
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lock_lat <= 1'b0;
            lock_cnt <= '0;
        end else if (grant) begin
            lock_lat <= win ? lock1 : lock0;
            if (!locked)         lock_cnt <= '0;
            else if (!lock_full) lock_cnt <= lock_cnt + 1'b1;
        end
    end
`endif

    assign mem_addr    = lat_addr;
    assign mem_wr_data = lat_wd;
    assign mem_wr_ena  = (state_q == ISSUE) & lat_we;
    assign busy        = (state_q != IDLE);
    assign gnt_id      = gnt_id_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rd_data0    = rd0_q;
    assign rd_data1    = rd1_q;

endmodule
